// File: rtl/uart_xfer_pkg.sv
// ----------------------------------------------------------------------------
// uart_xfer_pkg
// Shared definitions for the host file-transfer block:
//   - HDR_READ / HDR_WRITE : default header bytes ('R' / 'W')
//   - xfer_state_t         : top-level transfer state encoding
//   - hs_state_t           : byte-send handshake sub-state encoding
// ----------------------------------------------------------------------------
package uart_xfer_pkg;

   localparam logic [7:0] HDR_READ  = 8'h52;
   localparam logic [7:0] HDR_WRITE = 8'h57;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_SEND_HDR,
      ST_SEND_IDX_LO,
      ST_SEND_IDX_HI,
      ST_RD_BYTES,
      ST_WR_FETCH,
      ST_WR_LATCH,
      ST_DONE,
      ST_ERR
   } xfer_state_t;

   typedef enum logic [1:0] {
      HS_ISSUE,
      HS_WAIT_HI,
      HS_WAIT_LO
   } hs_state_t;

endpackage

// File: rtl/uart_tx_byte.sv
// ----------------------------------------------------------------------------
// uart_tx_byte
// Sends one byte to the UART core using a three-step handshake:
//   ISSUE   : wait for tx_busy low, present byte_in and pulse tx_en
//   WAIT_HI : wait for the core to raise tx_busy
//   WAIT_LO : wait for tx_busy low again, then pulse sent
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   send        : held high by the parent while it wants a byte sent
//   byte_in     : byte to send (must be stable while send is high)
//   tx_busy     : UART transmitter busy
//   tx_data     : byte to the UART core, held from ISSUE until WAIT_LO exits
//   tx_en       : one-cycle transmit strobe
//   sent        : one-cycle pulse when the handshake completes
// ----------------------------------------------------------------------------
module uart_tx_byte
   import uart_xfer_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       send,
   input  logic [7:0] byte_in,
   input  logic       tx_busy,
   output logic [7:0] tx_data,
   output logic       tx_en,
   output logic       sent
);

   hs_state_t  r_hs;
   hs_state_t  w_hs_next;
   logic [7:0] r_hold;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_hs   <= HS_ISSUE;
         r_hold <= 8'h00;
      end else begin
         r_hs <= w_hs_next;
         if (tx_en) begin
            r_hold <= byte_in;
         end
      end
   end

   // tx_en is combinational on tx_busy so the strobe can never land in a
   // cycle where the core already reports busy.
   always_comb begin
      w_hs_next = r_hs;
      tx_en     = 1'b0;
      sent      = 1'b0;
      tx_data   = r_hold;
      case (r_hs)
         HS_ISSUE: begin
            tx_data = send ? byte_in : 8'h00;
            if (send && !tx_busy && !reset) begin
               tx_en     = 1'b1;
               w_hs_next = HS_WAIT_HI;
            end
         end
         HS_WAIT_HI: begin
            if (tx_busy) begin
               w_hs_next = HS_WAIT_LO;
            end
         end
         HS_WAIT_LO: begin
            if (!tx_busy) begin
               sent      = 1'b1;
               w_hs_next = HS_ISSUE;
            end
         end
         default: w_hs_next = HS_ISSUE;
      endcase
   end

endmodule

// File: rtl/uart_file_xfer.sv
// ----------------------------------------------------------------------------
// uart_file_xfer
// Runs one host file transfer per accepted request: header byte, file index
// (LSB first), then a byte stream from the UART into memory (read) or from
// memory out to the UART (write). Pulses done on completion, err on RX timeout.
// Ports:
//   clk, reset                  : clock, synchronous active-high reset
//   start, rw, file_index       : request strobe, direction (1 = read), file id
//   mem_start, mem_end          : inclusive byte window
//   busy, done, err             : status; done/err are one-cycle pulses
//   mem_addr/mem_wdata/mem_we   : feature-memory port (write strobe)
//   mem_rdata                   : read data, one cycle after mem_addr
//   tx_data/tx_en/tx_busy       : UART transmit side
//   rx_data/rx_rdy              : UART receive side
// ----------------------------------------------------------------------------
module uart_file_xfer
   import uart_xfer_pkg::*;
#(
   parameter int unsigned ADDR_W     = 16,
   parameter logic [7:0]  HDR_READ   = uart_xfer_pkg::HDR_READ,
   parameter logic [7:0]  HDR_WRITE  = uart_xfer_pkg::HDR_WRITE,
   parameter logic [23:0] RX_TIMEOUT = 24'd10000000
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              rw,
   input  logic [15:0]       file_index,
   input  logic [ADDR_W-1:0] mem_start,
   input  logic [ADDR_W-1:0] mem_end,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_wdata,
   output logic              mem_we,
   input  logic [7:0]        mem_rdata,
   output logic [7:0]        tx_data,
   output logic              tx_en,
   input  logic              tx_busy,
   input  logic [7:0]        rx_data,
   input  logic              rx_rdy
);

   xfer_state_t       r_state;
   xfer_state_t       w_state_next;
   logic              r_rw;
   logic [15:0]       r_idx;
   logic [ADDR_W-1:0] r_start;
   logic [ADDR_W-1:0] r_end;
   logic [ADDR_W-1:0] r_ptr;
   logic [7:0]        r_wbyte;
   logic              r_cap;
   logic [23:0]       r_idle;

   logic              w_send;
   logic [7:0]        w_byte;
   logic              w_sent;
   logic              w_last;
   logic              w_empty;
   logic              w_timeout;
   logic              w_rd_write;

   assign w_last     = (r_ptr == r_end);
   assign w_empty    = (r_end < r_start);
   // Counter is zero in the cycle after entry/rx_rdy, so comparing against
   // RX_TIMEOUT-1 makes ERR follow RX_TIMEOUT cycles of silence.
   assign w_timeout  = (RX_TIMEOUT != 24'd0) && (r_idle == RX_TIMEOUT - 24'd1);
   assign w_rd_write = (r_state == ST_RD_BYTES) && rx_rdy;

   uart_tx_byte u_tx_byte (
      .clk     (clk),
      .reset   (reset),
      .send    (w_send),
      .byte_in (w_byte),
      .tx_busy (tx_busy),
      .tx_data (tx_data),
      .tx_en   (tx_en),
      .sent    (w_sent)
   );

   always_comb begin
      w_state_next = r_state;
      w_send       = 1'b0;
      w_byte       = 8'h00;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_state_next = ST_SEND_HDR;
            end
         end
         ST_SEND_HDR: begin
            w_send = 1'b1;
            w_byte = r_rw ? HDR_READ : HDR_WRITE;
            if (w_sent) begin
               w_state_next = ST_SEND_IDX_LO;
            end
         end
         ST_SEND_IDX_LO: begin
            w_send = 1'b1;
            w_byte = r_idx[7:0];
            if (w_sent) begin
               w_state_next = ST_SEND_IDX_HI;
            end
         end
         ST_SEND_IDX_HI: begin
            w_send = 1'b1;
            w_byte = r_idx[15:8];
            if (w_sent) begin
               if (w_empty) begin
                  w_state_next = ST_DONE;
               end else if (r_rw) begin
                  w_state_next = ST_RD_BYTES;
               end else begin
                  w_state_next = ST_WR_FETCH;
               end
            end
         end
         ST_RD_BYTES: begin
            if (rx_rdy) begin
               if (w_last) begin
                  w_state_next = ST_DONE;
               end
            end else if (w_timeout) begin
               w_state_next = ST_ERR;
            end
         end
         ST_WR_FETCH: begin
            w_state_next = ST_WR_LATCH;
         end
         ST_WR_LATCH: begin
            // First WR_LATCH cycle captures mem_rdata; the send starts after.
            w_send = r_cap;
            w_byte = r_wbyte;
            if (w_sent) begin
               w_state_next = w_last ? ST_DONE : ST_WR_FETCH;
            end
         end
         ST_DONE: w_state_next = ST_IDLE;
         ST_ERR:  w_state_next = ST_IDLE;
         default: w_state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_rw    <= 1'b0;
         r_idx   <= 16'h0000;
         r_start <= '0;
         r_end   <= '0;
         r_ptr   <= '0;
         r_wbyte <= 8'h00;
         r_cap   <= 1'b0;
         r_idle  <= 24'd0;
      end else begin
         r_state <= w_state_next;

         if (r_state == ST_IDLE && start) begin
            r_rw    <= rw;
            r_idx   <= file_index;
            r_start <= mem_start;
            r_end   <= mem_end;
            r_ptr   <= mem_start;
         end

         // Equality stop test: ptr is never advanced past mem_end.
         if (w_rd_write && !w_last) begin
            r_ptr <= r_ptr + ADDR_W'(1);
         end
         if (r_state == ST_WR_LATCH && w_sent && !w_last) begin
            r_ptr <= r_ptr + ADDR_W'(1);
         end

         if (r_state == ST_WR_LATCH) begin
            if (!r_cap) begin
               r_wbyte <= mem_rdata;
            end
            r_cap <= 1'b1;
         end else begin
            r_cap <= 1'b0;
         end

         if (r_state != ST_RD_BYTES || rx_rdy) begin
            r_idle <= 24'd0;
         end else begin
            r_idle <= r_idle + 24'd1;
         end
      end
   end

   assign busy      = (r_state != ST_IDLE) && (r_state != ST_DONE) && (r_state != ST_ERR);
   assign done      = (r_state == ST_DONE) && !reset;
   assign err       = (r_state == ST_ERR) && !reset;
   assign mem_we    = w_rd_write && !reset;
   assign mem_wdata = mem_we ? rx_data : 8'h00;
   assign mem_addr  = r_ptr;

endmodule

// File: tb/tb_uart_file_xfer.sv
module tb_uart_file_xfer;

   localparam int         AW  = 16;
   localparam logic [7:0] H_R = 8'h52;
   localparam logic [7:0] H_W = 8'h57;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic          rw;
   logic [15:0]   file_index;
   logic [AW-1:0] mem_start;
   logic [AW-1:0] mem_end;
   logic          busy;
   logic          done;
   logic          err;
   logic [AW-1:0] mem_addr;
   logic [7:0]    mem_wdata;
   logic          mem_we;
   logic [7:0]    mem_rdata;
   logic [7:0]    tx_data;
   logic          tx_en;
   logic          tx_busy;
   logic [7:0]    rx_data;
   logic          rx_rdy;

   always #5 clk = ~clk;

   uart_file_xfer #(
      .ADDR_W     (AW),
      .RX_TIMEOUT (24'd100)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .rw         (rw),
      .file_index (file_index),
      .mem_start  (mem_start),
      .mem_end    (mem_end),
      .busy       (busy),
      .done       (done),
      .err        (err),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_we     (mem_we),
      .mem_rdata  (mem_rdata),
      .tx_data    (tx_data),
      .tx_en      (tx_en),
      .tx_busy    (tx_busy),
      .rx_data    (rx_data),
      .rx_rdy     (rx_rdy)
   );

   // Synchronous feature memory with a bench-side preload port.
   logic [7:0]    mem [0:65535];
   logic          pl_we;
   logic [AW-1:0] pl_addr;
   logic [7:0]    pl_data;

   always @(posedge clk) begin
      mem_rdata <= mem[mem_addr];
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else if (pl_we) mem[pl_addr] <= pl_data;
   end

   // Reference model state and scoreboard queues.
   logic [7:0]      ref_mem [0:511];
   logic [7:0]      exp_tx[$];
   logic [AW+7:0]   exp_wr[$];
   int              exp_ev[$];   // 1 = done, 2 = err
   logic [7:0]      rx_plan[$];

   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;
   int tx_count = 0;
   int last_rx_cyc = 0;
   bit inflight = 1'b0;
   bit slow = 1'b0;
   int busy_len = 6;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h (cycle %0d)", nm, act, req, cyc);
      end
   endtask

   // UART transmitter model: busy for busy_len cycles per byte; in slow mode
   // it drops busy for one cycle, then holds it high 50 more cycles.
   initial begin
      tx_busy = 1'b0;
      forever begin
         @(negedge clk);
         if (tx_en) begin
            inflight = 1'b1;
            @(posedge clk); #1 tx_busy = 1'b1;
            repeat (busy_len) @(posedge clk);
            #1 tx_busy = 1'b0;
            inflight = 1'b0;
            if (slow) begin
               @(posedge clk); #1 tx_busy = 1'b1;
               repeat (50) @(posedge clk);
               #1 tx_busy = 1'b0;
            end
         end
      end
   end

   // Monitor: pops expectations whenever the DUT presents an output event.
   initial begin
      logic [7:0] last_tx;
      bit         aborted;
      int         lat;
      last_tx = 8'h00;
      aborted = 1'b0;
      forever begin
         @(negedge clk);
         if (reset) aborted = 1'b1;
         if (rx_rdy) last_rx_cyc = cyc;
         if (tx_en) begin
            chk("tx_en_while_busy", 32'(tx_busy), 32'd0);
            n_chk++;
            if (exp_tx.size() == 0) begin
               n_fail++;
               $display("FAIL tx_extra: got byte %02h, required no transmission (cycle %0d)", tx_data, cyc);
            end else begin
               logic [7:0] e;
               e = exp_tx.pop_front();
               if (tx_data !== e) begin
                  n_fail++;
                  $display("FAIL tx_byte: got %02h, required %02h (cycle %0d)", tx_data, e, cyc);
               end
            end
            $display("tx  byte %02h at cycle %0d", tx_data, cyc);
            last_tx  = tx_data;
            aborted  = 1'b0;
            tx_count++;
         end else if (inflight && !aborted) begin
            chk("tx_data_hold", 32'(tx_data), 32'(last_tx));
         end
         if (mem_we) begin
            n_chk++;
            if (exp_wr.size() == 0) begin
               n_fail++;
               $display("FAIL mem_extra: got write %04h=%02h, required no write", mem_addr, mem_wdata);
            end else begin
               logic [AW+7:0] w;
               w = exp_wr.pop_front();
               if ({mem_addr, mem_wdata} !== w) begin
                  n_fail++;
                  $display("FAIL mem_write: got %04h=%02h, required %04h=%02h",
                           mem_addr, mem_wdata, w[AW+7:8], w[7:0]);
               end
            end
            $display("mem write %04h=%02h at cycle %0d", mem_addr, mem_wdata, cyc);
         end
         if (done || err) begin
            int code;
            code = done ? 1 : 2;
            n_chk++;
            if (exp_ev.size() == 0) begin
               n_fail++;
               $display("FAIL event_extra: got %s, required none", done ? "done" : "err");
            end else begin
               int e;
               e = exp_ev.pop_front();
               if (code != e || (done && err)) begin
                  n_fail++;
                  $display("FAIL event_kind: got done=%0b err=%0b, required code %0d", done, err, e);
               end
            end
            chk("busy_at_end_pulse", 32'(busy), 32'd0);
            $display("end event %s at cycle %0d", done ? "done" : "err", cyc);
            if (err) begin
               lat = cyc - last_rx_cyc;
               n_chk++;
               if (lat < 99 || lat > 103) begin
                  n_fail++;
                  $display("FAIL err_latency: got %0d cycles after last rx_rdy, required about 100", lat);
               end
            end
         end
      end
   end

   task automatic wait_clk(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_rx(input logic [7:0] b);
      @(posedge clk); #1 rx_data = b; rx_rdy = 1'b1;
      @(posedge clk); #1 rx_rdy = 1'b0; rx_data = 8'h00;
   endtask

   task automatic wait_drain(input string nm, input int limit);
      int k;
      k = 0;
      while ((exp_ev.size() != 0 || exp_tx.size() != 0 || exp_wr.size() != 0) && k < limit) begin
         @(posedge clk);
         k++;
      end
      #1;
      n_chk++;
      if (exp_ev.size() != 0 || exp_tx.size() != 0 || exp_wr.size() != 0) begin
         n_fail++;
         $display("FAIL %s_drain: got pending tx=%0d wr=%0d ev=%0d, required all 0",
                  nm, exp_tx.size(), exp_wr.size(), exp_ev.size());
      end
      wait_clk(2);
      chk({nm, "_busy_idle"}, 32'(busy), 32'd0);
   endtask

   // Issue one request; the model derives every expected byte/write/event.
   // rx_limit caps how many data bytes the host actually sends.
   task automatic request(input string nm, input bit r, input logic [15:0] idx,
                          input logic [AW-1:0] s, input logic [AW-1:0] e,
                          input bit stray, input int rx_limit);
      int n, base, k;
      logic [7:0] bytes[$];
      logic [AW-1:0] a;
      n = (e < s) ? 0 : (int'(e) - int'(s) + 1);
      exp_tx.push_back(r ? H_R : H_W);
      exp_tx.push_back(idx[7:0]);
      exp_tx.push_back(idx[15:8]);
      for (int i = 0; i < n; i++) begin
         a = s + AW'(i);
         if (r) begin
            bytes.push_back((i < rx_plan.size()) ? rx_plan[i] : 8'($urandom));
            if (i < rx_limit) begin
               exp_wr.push_back({a, bytes[i]});
               ref_mem[a[8:0]] = bytes[i];
            end
         end else begin
            exp_tx.push_back(ref_mem[a[8:0]]);
         end
      end
      exp_ev.push_back((r && n > rx_limit) ? 2 : 1);
      rx_plan.delete();
      $display("req %s rw=%0b idx=%04h window %0d..%0d bytes=%0d", nm, r, idx, s, e, n);
      base = tx_count;
      @(posedge clk); #1;
      start = 1'b1; rw = r; file_index = idx; mem_start = s; mem_end = e;
      @(posedge clk); #1;
      start = 1'b0; rw = 1'($urandom); file_index = 16'($urandom);
      mem_start = AW'($urandom); mem_end = AW'($urandom);
      wait_clk(1);
      if (stray) send_rx(8'($urandom));
      start = 1'b1;            // ignored: transfer already running
      wait_clk(1);
      start = 1'b0;
      if (r && n > 0) begin
         k = 0;
         while (!(tx_count >= base + 3 && !inflight) && k < 3000) begin
            @(posedge clk);
            k++;
         end
         if (k >= 3000) begin
            n_chk++; n_fail++;
            $display("FAIL %s_hdr_wait: got %0d tx bytes, required 3 within 3000 cycles", nm, tx_count - base);
         end
         wait_clk(3);
         for (int i = 0; i < n && i < rx_limit; i++) begin
            wait_clk($urandom_range(0, 15));
            send_rx(bytes[i]);
         end
      end
      wait_drain(nm, 5000);
   endtask

   initial begin
      #600000;
      $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int k, base;
      reset = 1'b1; start = 1'b0; rw = 1'b0; file_index = 16'h0;
      mem_start = '0; mem_end = '0; rx_data = 8'h00; rx_rdy = 1'b0;
      pl_we = 1'b0; pl_addr = '0; pl_data = 8'h00;
      for (int i = 0; i < 512; i++) ref_mem[i] = 8'($urandom);
      ref_mem[100] = 8'h11; ref_mem[101] = 8'h22; ref_mem[102] = 8'h33;
      for (int i = 0; i < 512; i++) begin
         pl_we = 1'b1; pl_addr = AW'(i); pl_data = ref_mem[i];
         @(posedge clk); #1;
      end
      pl_we = 1'b0;
      @(negedge clk);
      chk("rst_busy", 32'(busy), 0);       chk("rst_done", 32'(done), 0);
      chk("rst_err", 32'(err), 0);         chk("rst_mem_we", 32'(mem_we), 0);
      chk("rst_tx_en", 32'(tx_en), 0);     chk("rst_tx_data", 32'(tx_data), 0);
      chk("rst_mem_addr", 32'(mem_addr), 0); chk("rst_mem_wdata", 32'(mem_wdata), 0);
      @(posedge clk); #1 reset = 1'b0;
      wait_clk(3);

      // Directed read: host sends AA BB CC DD into 0..3.
      rx_plan = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
      request("read_fixed", 1'b1, 16'h0102, 16'd0, 16'd3, 1'b1, 99);
      chk("mem0", 32'(mem[0]), 32'hAA); chk("mem1", 32'(mem[1]), 32'hBB);
      chk("mem2", 32'(mem[2]), 32'hCC); chk("mem3", 32'(mem[3]), 32'hDD);

      // Directed write: 100..102 preloaded 11,22,33.
      request("write_fixed", 1'b0, 16'h0041, 16'd100, 16'd102, 1'b0, 99);

      // Slow UART: busy held high 50 cycles before each byte.
      slow = 1'b1; busy_len = 50;
      request("write_slow", 1'b0, 16'hBEEF, 16'd300, 16'd303, 1'b0, 99);
      slow = 1'b0; busy_len = 6;

      // Empty window with a stray rx_rdy during the header.
      request("empty", 1'b1, 16'h1234, 16'd5, 16'd4, 1'b1, 99);

      // RX timeout after 2 of 4 bytes, then a fresh request is accepted.
      request("timeout", 1'b1, 16'h0777, 16'd20, 16'd23, 1'b0, 2);
      request("after_err", 1'b0, 16'h0003, 16'd20, 16'd21, 1'b0, 99);

      // Reset in the middle of a write stream.
      for (int i = 200; i < 220; i++) exp_tx.push_back(ref_mem[i]);
      exp_tx.push_front(8'h00); exp_tx.push_front(8'h09); exp_tx.push_front(H_W);
      exp_ev.push_back(1);
      base = tx_count;
      @(posedge clk); #1;
      start = 1'b1; rw = 1'b0; file_index = 16'h0009; mem_start = 16'd200; mem_end = 16'd219;
      @(posedge clk); #1 start = 1'b0;
      k = 0;
      while (tx_count < base + 6 && k < 3000) begin @(posedge clk); k++; end
      if (k >= 3000) begin
         n_chk++; n_fail++;
         $display("FAIL reset_stream_wait: got %0d tx bytes, required 6", tx_count - base);
      end
      @(posedge clk); #1 reset = 1'b1;
      exp_tx.delete(); exp_wr.delete(); exp_ev.delete();
      @(posedge clk); #1 reset = 1'b0;
      @(negedge clk);
      chk("mid_rst_busy", 32'(busy), 0);       chk("mid_rst_done", 32'(done), 0);
      chk("mid_rst_err", 32'(err), 0);         chk("mid_rst_mem_we", 32'(mem_we), 0);
      chk("mid_rst_tx_en", 32'(tx_en), 0);     chk("mid_rst_tx_data", 32'(tx_data), 0);
      chk("mid_rst_mem_addr", 32'(mem_addr), 0); chk("mid_rst_mem_wdata", 32'(mem_wdata), 0);
      k = 0;
      while (tx_busy && k < 500) begin @(posedge clk); k++; end
      wait_clk(20);
      request("read_after_rst", 1'b1, 16'h0A0B, 16'd40, 16'd45, 1'b0, 99);

      // Randomised requests.
      for (int t = 0; t < 8; t++) begin
         logic [AW-1:0] s;
         int len;
         s   = AW'($urandom_range(1, 400));
         len = $urandom_range(0, 6);
         request("random", 1'($urandom), 16'($urandom), s, s + AW'(len) - AW'(1),
                 1'($urandom), 99);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
